// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op encodings for MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   - FSM state encoding
//   - iteration counter width helper
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // Counter must hold 0..WIDTH, hence one bit beyond clog2.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation.
//   en   : 1 negates din, 0 passes it through
//   din  : WIDTH-bit operand
//   dout : din or -din
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = en ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   start, op     : launch MULT/MULTU/DIV/DIVU (multi-cycle) or MTHI/MTLO
//   a, b          : rs / rt operands, latched at launch
//   rd_hi, rdata  : combinational MFHI/MFLO read
//   hi, lo        : HI/LO registers
//   busy          : multi-cycle operation in flight
//   done, div0    : one-cycle completion pulse / divide-by-zero pulse
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   acc;     // mul: {carry, partial hi, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0]   opb;     // multiplicand / divisor magnitude
  logic               sgn_q;   // product or quotient sign
  logic               sgn_r;   // remainder sign (dividend sign)
  logic               dz;      // divisor was zero
  logic               is_div;

  logic               sgnd, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign sgnd  = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg = sgnd & a[WIDTH-1];
  assign b_neg = sgnd & b[WIDTH-1];

  muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (.en(a_neg), .din(a), .dout(a_mag));
  muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (.en(b_neg), .din(b), .dout(b_mag));

  // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
  assign mul_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opb} : '0);

  // Restoring divide: shift left, trial-subtract divisor from the partial remainder.
  assign div_sh    = {acc[2*WIDTH-1:0], 1'b0};
  assign div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, opb};

  muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_p (.en(sgn_q), .din(acc[2*WIDTH-1:0]), .dout(prod_fix));
  muldiv_negate #(.WIDTH(WIDTH))   u_fix_q (.en(sgn_q), .din(acc[WIDTH-1:0]),   .dout(q_fix));
  muldiv_negate #(.WIDTH(WIDTH))   u_fix_r (.en(sgn_r), .din(acc[2*WIDTH-1:WIDTH]), .dout(r_fix));

  assign busy  = (state != ST_IDLE);
  assign rdata = rd_hi ? hi : lo;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MULT || op == OP_MULTU)    state_nx = ST_MUL;
          else if (op == OP_DIV || op == OP_DIVU) state_nx = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (cnt == CW'(WIDTH-1)) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Architectural and control state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      div0 <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_MTHI)      hi  <= a;
            else if (op == OP_MTLO) lo  <= a;
            else                    cnt <= '0;
          end
        end
        ST_MUL, ST_DIV: cnt <= cnt + CW'(1);
        ST_FIX: begin
          if (is_div) begin
            // Divide by zero: remainder fix already restores the raw dividend.
            lo <= dz ? '1 : q_fix;
            hi <= r_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done <= 1'b1;
          div0 <= is_div & dz;
        end
        default: ;
      endcase
    end
  end

  // Iteration datapath
  always_ff @(posedge clock) begin
    case (state)
      ST_IDLE: begin
        if (start) begin
          is_div <= (op == OP_DIV) || (op == OP_DIVU);
          sgn_q  <= a_neg ^ b_neg;
          sgn_r  <= a_neg;
          dz     <= (b == '0);
          if (op == OP_DIV || op == OP_DIVU) begin
            opb <= b_mag;
            acc <= {{(WIDTH+1){1'b0}}, a_mag};
          end else begin
            opb <= a_mag;
            acc <= {{(WIDTH+1){1'b0}}, b_mag};
          end
        end
      end
      ST_MUL: acc <= {1'b0, mul_sum, acc[WIDTH-1:1]};
      ST_DIV: begin
        if (!div_trial[WIDTH]) acc <= {div_trial, div_sh[WIDTH-1:1], 1'b1};
        else                   acc <= div_sh;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU. It takes the same rs/rt operand buses (a, b) the ALU uses.
- Holds the architectural HI/LO registers and supplies MFHI/MFLO data to the writeback mux alongside the ALU result s.
- Drives busy so the controller can stall issue until a multi-cycle operation completes.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  launch an operation; sampled on the rising edge.
- op  in  3  operation code (see Decomposition).
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data).
- b  in  WIDTH  rt operand (divisor / multiplier).
- rd_hi  in  1  read select: 1 puts HI on rdata, 0 puts LO on rdata.
- rdata  out  WIDTH  combinational read of HI or LO, for MFHI/MFLO writeback.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse: HI/LO updated by MULT/MULTU/DIV/DIVU.
- div0  out  1  one-cycle pulse, coincident with done, when the divisor was zero.

Behaviour:
- Reset, asynchronous while resetn=0:
  - state=IDLE, hi=0, lo=0, counter=0, busy=0, done=0, div0=0.
  - Reset mid-operation aborts the operation; no partial HI/LO write.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, start=1 at edge E0:
  - op MULT/MULTU: latch |a|,|b| (signed) or a,b (unsigned) and the result sign; clear accumulator; counter=0; go to MUL; busy=1 from E0.
  - op DIV/DIVU: latch magnitudes, quotient sign (sa^sb) and remainder sign (sa); go to DIV.
  - op MTHI: hi<=a at E0; stay IDLE; no busy, no done.
  - op MTLO: lo<=a at E0; stay IDLE; no busy, no done.
  - Undefined op codes: no effect.
- MUL: one shift-add iteration per edge, E1..E_WIDTH, building a 2*WIDTH product. When counter reaches WIDTH-1, go to FIX.
- DIV: one restoring shift-subtract iteration per edge, E1..E_WIDTH.
  - Quotient bit = 1 when the trial remainder >= 0.
  - Go to FIX after WIDTH iterations.
- FIX, edge E(WIDTH+1):
  - Apply two's-complement negation per the latched signs.
  - Write {hi,lo}=product; or lo=quotient, hi=remainder.
  - Return to IDLE; busy=0; done=1 for exactly the following cycle.
  - Total: HI/LO valid and done=1 in the cycle after E33 for WIDTH=32.
- Division rules:
  - Remainder takes the sign of the dividend; quotient truncates toward zero.
  - b=0: lo=all-ones, hi=a (raw, unsigned and signed); div0=1 with done; still full latency.
  - Signed 0x80000000 / -1: lo=0x80000000, hi=0; no flag.
- start while busy=1: ignored; MTHI/MTLO while busy also ignored. The controller must stall, so dropping the request is defined behaviour.
- Operands a/b may change after E0; latched copies are used throughout.
- rdata is purely combinational from hi/lo and rd_hi. MFHI during busy returns the old HI.
- All arithmetic is WIDTH-bit two's complement. The accumulator is 2*WIDTH+1 bits internally; no other width extension.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings: MULT=3'b000, MULTU=3'b001, DIV=3'b010, DIVU=3'b011, MTHI=3'b100, MTLO=3'b101.
  - State encodings IDLE/MUL/DIV/FIX.
  - Counter width constant, clog2(WIDTH)+1.
- One natural sub-module: muldiv_negate, a conditional two's-complement on WIDTH bits. It is reused for input magnitude and output sign fix.
- The datapath and FSM otherwise stay in one module.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high E0..E33; done single pulse after E33.
- MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100; div0=1 with done.
- MTHI a=0x12345678, then MFHI (rd_hi=1) -> rdata=0x12345678 next cycle, busy never set. Then start MULT at E0 with MTLO pulsed at E5 -> MTLO ignored; final lo is the product.
- Start DIVU, deassert resetn at E10 -> hi=lo=0, busy=0 immediately, no done. After release, a new MULTU 6*7 -> lo=42, hi=0.
